// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_sequencer_pkg;

  // Next-PC source, listed from lowest to highest precedence once en is high.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_INC,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_RETI,
    SEL_IRQ
  } sel_e;

  // Saved {z,n} flag pair carried in every stack frame.
  localparam int unsigned FLAG_W = 2;

  // Stack frame = return address followed by the saved flags.
  function automatic int unsigned frame_w(input int unsigned aw);
    return aw + FLAG_W;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit and the PC sequencer.
interface pc_sequencer_if #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NIRQ  = 4
);
  localparam int unsigned SPW = $clog2(DEPTH + 1);

  logic            en;
  logic            s_inc;
  logic [AW-1:0]   jmp_addr;
  logic            call;
  logic            ret;
  logic            reti;
  logic            ie_set;
  logic            ie_clr;
  logic [NIRQ-1:0] irq;
  logic [1:0]      flags_in;

  logic [AW-1:0]   pc;
  logic [1:0]      flags_rst;
  logic            flags_rst_v;
  logic [NIRQ-1:0] irq_ack;
  logic            in_isr;
  logic [SPW-1:0]  sp;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_err;

  modport master (
    output en, s_inc, jmp_addr, call, ret, reti, ie_set, ie_clr, irq, flags_in,
    input  pc, flags_rst, flags_rst_v, irq_ack, in_isr, sp, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  en, s_inc, jmp_addr, call, ret, reti, ie_set, ie_clr, irq, flags_in,
    output pc, flags_rst, flags_rst_v, irq_ack, in_isr, sp, stk_full, stk_empty, stk_err
  );

endinterface

// File: rtl/pc_sequencer_pila.sv
// Hardware return stack (LIFO) with registered occupancy and
// combinational top-of-stack read. Entries are not reset.
module pila_param #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 tos_o,
  output logic [$clog2(DEPTH+1)-1:0]   sp_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         err_o
);
  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           wr_ok, rd_ok;

  // Pop has precedence; a refused access (overflow/underflow) leaves sp alone.
  always_comb begin
    rd_ok   = pop_i & ~empty_q;
    wr_ok   = push_i & ~pop_i & ~full_q;
    err_o   = (pop_i & empty_q) | (push_i & ~pop_i & full_q);
    sp_d    = sp_q;
    if (rd_ok) begin
      sp_d = sp_q - SPW'(1);
    end else if (wr_ok) begin
      sp_d = sp_q + SPW'(1);
    end
    full_d  = (sp_d == SPW'(DEPTH));
    empty_d = (sp_d == '0);
  end

  // Occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage write at the current occupancy slot.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[AIW'(sp_q)] <= din_i;
    end
  end

  assign tos_o   = mem[AIW'(sp_q - SPW'(1))];
  assign sp_o    = sp_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, incrementer, jump, call/return
// through a hardware stack, and vectored interrupts with Z/N save/restore.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned AW       = 10,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NIRQ     = 4,
  parameter int unsigned VEC_BASE = 32'h3F0
) (
  input  logic         clk,
  input  logic         reset,
  pc_sequencer_if.slave bus
);
  localparam int unsigned FW   = frame_w(AW);
  localparam int unsigned SPW  = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [AW-1:0]   pc_q, pc_d;
  logic            ie_q, ie_d;
  logic            in_isr_q, in_isr_d;
  logic [NIRQ-1:0] irq_ack_q, irq_ack_d;
  logic [1:0]      flags_rst_q, flags_rst_d;
  logic            flags_rst_v_q, flags_rst_v_d;
  logic            stk_err_q, stk_err_d;

  logic [AW-1:0]   pc_inc, pc_seq, vec_addr;
  logic            do_pop, irq_take, illegal;
  logic [IDXW-1:0] irq_idx;
  sel_e            sel;

  logic            push, pop;
  logic [FW-1:0]   push_frame, tos;
  logic [SPW-1:0]  sp;
  logic            full, empty, op_err;

  // Lowest-numbered active request wins.
  always_comb begin
    irq_idx = '0;
    for (int unsigned i = NIRQ; i > 0; i--) begin
      if (bus.irq[i-1]) begin
        irq_idx = IDXW'(i - 1);
      end
    end
  end

  assign pc_inc   = pc_q + AW'(1);
  assign pc_seq   = bus.s_inc ? pc_inc : bus.jmp_addr;
  assign vec_addr = AW'(VEC_BASE) + AW'(irq_idx);
  assign do_pop   = bus.ret | bus.reti;
  assign irq_take = ie_q & ~in_isr_q & (|bus.irq) & ~bus.call & ~do_pop;
  assign illegal  = bus.en & bus.call & do_pop;

  // Next-PC source selection; ret+reti collapses to reti, any pop beats call.
  always_comb begin
    sel = SEL_HOLD;
    if (bus.en) begin
      if (irq_take) begin
        sel = SEL_IRQ;
      end else if (bus.reti) begin
        sel = SEL_RETI;
      end else if (bus.ret) begin
        sel = SEL_RET;
      end else if (bus.call) begin
        sel = SEL_CALL;
      end else if (!bus.s_inc) begin
        sel = SEL_JMP;
      end else begin
        sel = SEL_INC;
      end
    end
  end

  // Stack requests; an interrupt saves the address this cycle would have gone to.
  always_comb begin
    push       = (sel == SEL_IRQ) || (sel == SEL_CALL);
    pop        = (sel == SEL_RET) || (sel == SEL_RETI);
    push_frame = (sel == SEL_IRQ) ? {pc_seq, bus.flags_in} : {pc_inc, bus.flags_in};
  end

  pila_param #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_frame),
    .tos_o   (tos),
    .sp_o    (sp),
    .full_o  (full),
    .empty_o (empty),
    .err_o   (op_err)
  );

  // Next-state for PC, interrupt state, pulses and the sticky error.
  always_comb begin
    pc_d          = pc_q;
    ie_d          = ie_q;
    in_isr_d      = in_isr_q;
    irq_ack_d     = '0;
    flags_rst_d   = flags_rst_q;
    flags_rst_v_d = 1'b0;
    stk_err_d     = stk_err_q | op_err | illegal;

    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_INC:  pc_d = pc_inc;
      SEL_JMP:  pc_d = bus.jmp_addr;
      SEL_CALL: pc_d = bus.jmp_addr;
      SEL_RET:  pc_d = empty ? pc_inc : tos[FW-1:FLAG_W];
      SEL_RETI: begin
        pc_d     = empty ? pc_inc : tos[FW-1:FLAG_W];
        in_isr_d = 1'b0;
        ie_d     = 1'b1;
        if (!empty) begin
          flags_rst_d   = tos[FLAG_W-1:0];
          flags_rst_v_d = 1'b1;
        end
      end
      SEL_IRQ: begin
        pc_d      = vec_addr;
        irq_ack_d = NIRQ'(1) << irq_idx;
        in_isr_d  = 1'b1;
        ie_d      = 1'b0;
      end
      default: pc_d = pc_q;
    endcase

    // Explicit enable strobes are applied last so they govern the next IRQ check.
    if (bus.en) begin
      if (bus.ie_set) ie_d = 1'b1;
      if (bus.ie_clr) ie_d = 1'b0;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= '0;
      ie_q          <= 1'b0;
      in_isr_q      <= 1'b0;
      irq_ack_q     <= '0;
      flags_rst_q   <= '0;
      flags_rst_v_q <= 1'b0;
      stk_err_q     <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ie_q          <= ie_d;
      in_isr_q      <= in_isr_d;
      irq_ack_q     <= irq_ack_d;
      flags_rst_q   <= flags_rst_d;
      flags_rst_v_q <= flags_rst_v_d;
      stk_err_q     <= stk_err_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.flags_rst   = flags_rst_q;
  assign bus.flags_rst_v = flags_rst_v_q;
  assign bus.irq_ack     = irq_ack_q;
  assign bus.in_isr      = in_isr_q;
  assign bus.sp          = sp;
  assign bus.stk_full    = full;
  assign bus.stk_empty   = empty;
  assign bus.stk_err     = stk_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic,
// expectations from a queue-based behavioural model.
module tb_pc_sequencer;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NIRQ  = 4;
  localparam int unsigned VEC   = 32'h3F0;
  localparam int unsigned AMOD  = 1 << AW;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pc_sequencer_if #(.AW(AW), .DEPTH(DEPTH), .NIRQ(NIRQ)) bus ();

  pc_sequencer #(
    .AW       (AW),
    .DEPTH    (DEPTH),
    .NIRQ     (NIRQ),
    .VEC_BASE (VEC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned fl;
  } frame_t;

  typedef struct {
    int unsigned pc;
    int unsigned sp;
    int unsigned full;
    int unsigned empty;
    int unsigned err;
    int unsigned ack;
    int unsigned isr;
    int unsigned frst;
    int unsigned frv;
  } exp_t;

  exp_t        expq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // model state
  int unsigned m_pc, m_ie, m_isr, m_err, m_ack, m_frst, m_frv;
  frame_t      m_stk[$];

  function automatic void check(input string name, input logic [31:0] act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = 0; m_ie = 0; m_isr = 0; m_err = 0; m_ack = 0; m_frst = 0; m_frv = 0;
    m_stk.delete();
  endfunction

  function automatic void model_push(input int unsigned addr, input int unsigned fl);
    frame_t f;
    if (m_stk.size() >= DEPTH) begin
      m_err = 1;
    end else begin
      f.addr = addr; f.fl = fl;
      m_stk.push_back(f);
    end
  endfunction

  function automatic void model_step(input bit en, input bit s_inc, input int unsigned jmp,
                                     input bit call, input bit ret, input bit reti,
                                     input bit ie_set, input bit ie_clr,
                                     input int unsigned irq, input int unsigned flags);
    int unsigned seq, nseq, idx;
    bit          pop, take;
    frame_t      f;
    m_ack = 0;
    m_frv = 0;
    if (!en) return;
    seq  = (m_pc + 1) % AMOD;
    nseq = s_inc ? seq : jmp;
    pop  = ret || reti;
    take = (m_ie != 0) && (m_isr == 0) && (irq != 0) && !call && !pop;
    if (call && pop) m_err = 1;
    if (take) begin
      idx = 0;
      while (((irq >> idx) & 1) == 0) idx++;
      model_push(nseq, flags);
      m_pc  = (VEC + idx) % AMOD;
      m_ack = 1 << idx;
      m_isr = 1;
      m_ie  = 0;
    end else if (pop) begin
      if (m_stk.size() == 0) begin
        m_err = 1;
        m_pc  = seq;
      end else begin
        f    = m_stk.pop_back();
        m_pc = f.addr;
        if (reti) begin
          m_frst = f.fl;
          m_frv  = 1;
        end
      end
      if (reti) begin
        m_isr = 0;
        m_ie  = 1;
      end
    end else if (call) begin
      model_push(seq, flags);
      m_pc = jmp;
    end else begin
      m_pc = nseq;
    end
    if (ie_set) m_ie = 1;
    if (ie_clr) m_ie = 0;
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.pc    = m_pc;
    e.sp    = m_stk.size();
    e.full  = (m_stk.size() == DEPTH) ? 1 : 0;
    e.empty = (m_stk.size() == 0) ? 1 : 0;
    e.err   = m_err;
    e.ack   = m_ack;
    e.isr   = m_isr;
    e.frst  = m_frst;
    e.frv   = m_frv;
    return e;
  endfunction

  task automatic cyc(input bit en, input bit s_inc, input int unsigned jmp,
                     input bit call, input bit ret, input bit reti,
                     input bit ie_set, input bit ie_clr,
                     input int unsigned irq, input int unsigned flags);
    @(negedge clk);
    reset        = 1'b1;
    bus.en       = en;
    bus.s_inc    = s_inc;
    bus.jmp_addr = AW'(jmp);
    bus.call     = call;
    bus.ret      = ret;
    bus.reti     = reti;
    bus.ie_set   = ie_set;
    bus.ie_clr   = ie_clr;
    bus.irq      = NIRQ'(irq);
    bus.flags_in = 2'(flags);
    model_step(en, s_inc, jmp, call, ret, reti, ie_set, ie_clr, irq, flags);
    expq.push_back(snap());
  endtask

  task automatic inc();                 cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(int unsigned a);   cyc(1, 0, a, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic call(int unsigned a);  cyc(1, 1, a, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic ret();                 cyc(1, 1, 0, 0, 1, 0, 0, 0, 0, 0); endtask

  // Async reset away from the clock edge, checked before any edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_pc",    32'(bus.pc), 0);
    check("async_sp",    32'(bus.sp), 0);
    check("async_empty", 32'(bus.stk_empty), 1);
    check("async_full",  32'(bus.stk_full), 0);
    check("async_err",   32'(bus.stk_err), 0);
    expq.push_back(snap());
    @(negedge clk);
    expq.push_back(snap());
  endtask

  // Monitor: compare registered outputs one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("pc",          32'(bus.pc), e.pc);
        check("sp",          32'(bus.sp), e.sp);
        check("stk_full",    32'(bus.stk_full), e.full);
        check("stk_empty",   32'(bus.stk_empty), e.empty);
        check("stk_err",     32'(bus.stk_err), e.err);
        check("irq_ack",     32'(bus.irq_ack), e.ack);
        check("in_isr",      32'(bus.in_isr), e.isr);
        check("flags_rst",   32'(bus.flags_rst), e.frst);
        check("flags_rst_v", 32'(bus.flags_rst_v), e.frv);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0; bus.s_inc = 1'b1; bus.jmp_addr = '0; bus.call = 1'b0;
    bus.ret = 1'b0; bus.reti = 1'b0; bus.ie_set = 1'b0; bus.ie_clr = 1'b0;
    bus.irq = '0; bus.flags_in = '0;
    model_reset();
    do_reset();

    // Sequential, jump and wrap.
    inc(); inc(); inc();
    jmp(32'h200);
    jmp(32'h3FF);
    inc();

    // Nested call/return.
    jmp(32'h010);
    call(32'h100);
    inc();
    call(32'h180);
    ret();
    ret();

    // Interrupt entry, ISR with request held, reti restores flags.
    cyc(1, 0, 32'h020, 0, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 4'b0110, 2'b10);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 4'b0110, 2'b01);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 4'b0110, 2'b01);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 4'b0110, 2'b00);
    cyc(1, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00);

    // Overflow and underflow.
    do_reset();
    for (int i = 0; i < 5; i++) call(32'h100 + i);
    for (int i = 0; i < 5; i++) ret();
    inc();

    // Stall with pending IRQ and call, then IRQ deferred behind call.
    do_reset();
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 32'h150, 1, 0, 0, 0, 0, 4'b0001, 2'b11);
    cyc(0, 1, 32'h150, 1, 0, 0, 0, 0, 4'b0001, 2'b11);
    cyc(1, 1, 32'h150, 1, 0, 0, 0, 0, 4'b0001, 2'b11);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 2'b01);
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 2'b00);
    cyc(1, 1, 32'h0AA, 1, 1, 0, 0, 0, 4'b0000, 2'b00);

    // Reset mid-run with pc=0x05A, sp=3.
    do_reset();
    call(32'h05A); call(32'h05A); call(32'h05A);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      bit en, s_inc, c, r, ri, st, cl;
      int unsigned irq;
      if (n % 300 == 299) do_reset();
      en    = ($urandom_range(0, 99) < 90);
      s_inc = ($urandom_range(0, 99) < 70);
      c     = ($urandom_range(0, 99) < 8);
      r     = ($urandom_range(0, 99) < 6);
      ri    = ($urandom_range(0, 99) < 6);
      st    = ($urandom_range(0, 99) < 10);
      cl    = ($urandom_range(0, 99) < 4);
      irq   = ($urandom_range(0, 99) < 30) ? $urandom_range(1, 15) : 0;
      cyc(en, s_inc, $urandom_range(0, AMOD - 1), c, r, ri, st, cl, irq, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(expq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
